// File: rtl/rv32i.sv
// rv32i: shared load/store types and helpers for the RV32I data-memory path.
package rv32i;

    typedef enum logic [0:0] {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    // Unaligned base byte mask; the unused size code 3 behaves as a word.
    function automatic logic [3:0] size_mask(input mem_size_e size);
        case (size)
            SIZE_B:  return 4'b0001;
            SIZE_H:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // True when the access does not sit on its natural alignment.
    function automatic logic misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-enable generation, store-data lane shifting and
// load extract/extend over an 8-byte window {word_hi, word_lo}.
module dmem_lane_align
    import rv32i::*;
(
    input  mem_size_e   size,
    input  logic        zero_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [63:0] rwin,
    output logic [7:0]  be,
    output logic [63:0] wwin,
    output logic [31:0] rdata
);

    logic [4:0]  shamt;
    logic [63:0] shifted;
    logic        unused_shifted;

    // Shift everything by the byte offset, then pick and extend the load result.
    always_comb begin
        shamt   = {offset, 3'b000};
        be      = {4'b0000, size_mask(size)} << offset;
        wwin    = {32'h0000_0000, wdata} << shamt;
        shifted = rwin >> shamt;
        case (size)
            SIZE_B:  rdata = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
            SIZE_H:  rdata = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            default: rdata = shifted[31:0];
        endcase
    end

    assign unused_shifted = ^shifted[63:32];

endmodule

// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte/half/word data memory with valid/ready request, one-shot
// response, READ_LATENCY of 1 or 2 and misalignment handling.
// Optional macro DMEM_MISALIGN_SPLIT_EN: split misaligned accesses across two
// words instead of faulting them.
module dmem_bytelane
    import rv32i::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  mem_op_e     req_op,
    input  mem_size_e   req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("dmem_bytelane: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_bytelane: DEPTH_WORDS must be a power of two >= 2");
    end

    typedef enum logic [1:0] {StIdle, StWait, StSplit} state_e;

    state_e        state_q, state_d;
    logic [31:0]   mem [DEPTH_WORDS];
    logic          accept;
    mem_op_e       a_op;
    mem_size_e     a_size;
    logic          a_zext;
    logic [1:0]    a_off;
    logic [31:0]   a_wdata;
    logic [AW-1:0] a_idx;
    logic [63:0]   rwin, wwin;
    logic [7:0]    be;
    logic [31:0]   ld_data;
    logic [3:0]    we_lo;
    logic          done, rsp_set, pend_set;
    logic [31:0]   nxt_rdata;
    logic          nxt_fault;
    logic [31:0]   pend_rdata_q, rsp_rdata_q;
    logic          pend_fault_q, rsp_fault_q, rsp_valid_q;
    logic          unused_sink;

`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [AW-1:0] a_idx_hi;
    logic [3:0]    we_hi;
    mem_op_e       op_q;
    mem_size_e     size_q;
    logic          zext_q;
    logic [1:0]    off_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] idx_q;
`endif

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

    // Align path sees the live request in IDLE and the latched one while splitting.
    always_comb begin
        a_op    = req_op;
        a_size  = req_size;
        a_zext  = req_unsigned;
        a_off   = req_addr[1:0];
        a_wdata = req_wdata;
        a_idx   = req_addr[AW+1:2];
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state_q == StSplit) begin
            a_op    = op_q;
            a_size  = size_q;
            a_zext  = zext_q;
            a_off   = off_q;
            a_wdata = wdata_q;
            a_idx   = idx_q;
        end
`endif
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign a_idx_hi    = a_idx + AW'(1);
    assign rwin        = {mem[a_idx_hi], mem[a_idx]};
    assign unused_sink = ^req_addr[31:AW+2];
`else
    assign rwin        = {32'h0000_0000, mem[a_idx]};
    assign unused_sink = ^{be[7:4], wwin[63:32], req_addr[31:AW+2]};
`endif

    dmem_lane_align u_align (
        .size     (a_size),
        .zero_ext (a_zext),
        .offset   (a_off),
        .wdata    (a_wdata),
        .rwin     (rwin),
        .be       (be),
        .wwin     (wwin),
        .rdata    (ld_data)
    );

    // Next state, write enables and the response payload.
    always_comb begin
        state_d   = state_q;
        done      = 1'b0;
        rsp_set   = 1'b0;
        pend_set  = 1'b0;
        we_lo     = 4'b0000;
        nxt_rdata = 32'h0000_0000;
        nxt_fault = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        we_hi     = 4'b0000;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                    if (misaligned(a_size, a_off)) begin
                        if (a_op == MEM_STORE) we_lo = be[3:0];
                        state_d = StSplit;
                    end else begin
                        if (a_op == MEM_STORE) we_lo = be[3:0];
                        else                   nxt_rdata = ld_data;
                        done = 1'b1;
                    end
`else
                    if (misaligned(a_size, a_off)) nxt_fault = 1'b1;
                    else if (a_op == MEM_STORE)    we_lo = be[3:0];
                    else                           nxt_rdata = ld_data;
                    done = 1'b1;
`endif
                end
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            StSplit: begin
                if (a_op == MEM_STORE) we_hi = be[7:4];
                else                   nxt_rdata = ld_data;
                state_d = StIdle;
                done    = 1'b1;
            end
`endif
            StWait: begin
                rsp_set   = 1'b1;
                nxt_rdata = pend_rdata_q;
                nxt_fault = pend_fault_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Finished accesses respond next cycle, or park one cycle in WAIT.
        if (done) begin
            if (READ_LATENCY == 1) begin
                rsp_set = 1'b1;
            end else begin
                pend_set = 1'b1;
                state_d  = StWait;
            end
        end
    end

    // Control state and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_fault_q  <= 1'b0;
            pend_rdata_q <= 32'h0000_0000;
            pend_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_set;
            if (rsp_set) begin
                rsp_rdata_q <= nxt_rdata;
                rsp_fault_q <= nxt_fault;
            end
            if (pend_set) begin
                pend_rdata_q <= nxt_rdata;
                pend_fault_q <= nxt_fault;
            end
        end
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    // Latch the request so the second half of a split sees the same fields.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_op;
            size_q  <= req_size;
            zext_q  <= req_unsigned;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            idx_q   <= req_addr[AW+1:2];
        end
    end
`endif

    // Byte-masked writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < 4; b++) begin
                if (we_lo[b]) mem[a_idx][8*b +: 8] <= wwin[8*b +: 8];
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (we_hi[b]) mem[a_idx_hi][8*b +: 8] <= wwin[32+8*b +: 8];
`endif
            end
        end
    end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised successor of the core's single-port word RAM.
- Adds byte/half/word loads and stores with per-byte write enables, plus sign/zero extension on loads.
- Adds a valid/ready request and one-shot response handshake, configurable read latency, and misaligned-access detection.
- Sits between the RV32I execute/memory stage and on-chip block RAM as the data memory.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Must be a power of two, at least 2.
- READ_LATENCY, 1: cycles from request acceptance to response. Legal values are 1 or 2; any other value is an elaboration error.
- AW, $clog2(DEPTH_WORDS): derived word-index width. Not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_addr  input  32  byte address
- req_op  input  mem_op_e  MEM_LOAD or MEM_STORE
- req_size  input  mem_size_e  SIZE_B, SIZE_H or SIZE_W
- req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for stores and words
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and faults
- rsp_fault  output  1  misaligned access, valid with rsp_valid

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_fault=0, FSM=IDLE, so req_ready=1 from the first post-reset cycle. Memory array is not reset.
- Reset mid-operation: any pending response is dropped. A store committed before reset remains in memory.
- Handshake: accept when req_valid && req_ready. One request outstanding at most.
  - req_ready is 1 only in IDLE.
  - Requester holds its inputs stable until accepted.
  - Inputs are ignored while req_ready=0.
- FSM states: IDLE, WAIT, SPLIT.
  - IDLE, on accept, with READ_LATENCY=1: rsp_valid is asserted on the next cycle and the FSM stays in IDLE. This gives back-to-back throughput of one request per cycle.
  - IDLE, on accept, with READ_LATENCY=2: go to WAIT. One cycle later, WAIT issues the response and returns to IDLE.
  - SPLIT: used only under the optional feature.
- Addressing:
  - index = req_addr[AW+1:2]; offset = req_addr[1:0].
  - Address bits above AW+1 are ignored, so the memory aliases and wraps.
- Store:
  - Byte enables: be = {SIZE_B:0001, SIZE_H:0011, SIZE_W:1111} << offset, truncated to 4 bits.
  - Written data: lane data = req_wdata << (8*offset).
  - Only enabled bytes change. Stores are committed on the accept edge.
- Load:
  - word = mem[index]; shifted = word >> (8*offset).
  - SIZE_B result: bits 7:0 of shifted, sign- or zero-extended.
  - SIZE_H result: bits 15:0 of shifted, sign- or zero-extended.
  - SIZE_W result: the whole word.
- Misaligned access:
  - Definition: SIZE_H with offset[0]=1, or SIZE_W with offset!=0.
  - Without the optional feature: no write occurs. The response comes at normal latency with rsp_fault=1 and rsp_rdata=0.
- Response: rsp_valid is high for exactly one cycle per accepted request, stores included.
- Output hold: between responses, rsp_rdata and rsp_fault hold their last values and rsp_valid=0.

Optional Feature:
- Macro: DMEM_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split into two word accesses, first at index, then at (index+1) mod DEPTH_WORDS.
  - 8-byte window: the pair {mem[index+1], mem[index]}.
  - Store: byte enables span both words; each half is written on its own accept/SPLIT edge.
  - Load: bytes are concatenated from both words, then extended.
  - Latency: READ_LATENCY+1 cycles.
  - State path: IDLE -> SPLIT, then through WAIT if READ_LATENCY=2, then back to IDLE.
  - rsp_fault is never asserted.
- Undefined: fault behaviour as above; the SPLIT state is not synthesised.

Decomposition:
- Package rv32i holds:
  - mem_op_e, extended with MEM_LOAD if it is not already present;
  - new mem_size_e (2-bit: SIZE_B=0, SIZE_H=1, SIZE_W=2);
  - function misaligned(size, offset).
- One combinational sub-module, dmem_lane_align, contains the byte-enable generation, write-data shifting and load extract/extend. The FSM and array live in dmem_bytelane.

Test Plan:
- Word store then load: SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF, rsp_fault=0. rsp_valid arrives 1 cycle after accept at READ_LATENCY=1, 2 cycles after at READ_LATENCY=2.
- Byte lanes: SW 0x11223344 @0x20; SB 0xA5 @0x22; then:
  - LW → 0x11A53344;
  - LB @0x22 → 0xFFFFFFA5;
  - LBU @0x22 → 0x000000A5;
  - LH @0x22 → 0x000011A5.
- Misaligned, macro undefined: SW 0x12345678 @0x31 → rsp_fault=1, rsp_rdata=0; a following LW @0x30 returns its prior contents unchanged.
- Misaligned, macro defined: SW 0xAABBCCDD @0x42 → mem[0x40]=0xCCDDxxxx, mem[0x44]=0xxxxxAABB (x = prior bytes). LW @0x42 → 0xAABBCCDD, latency READ_LATENCY+1, rsp_fault=0. Also check wrap: the same access at the top word pairs with word 0.
- Handshake and reset: back-to-back loads at READ_LATENCY=1 with req_valid held high → one response per cycle, in order. At READ_LATENCY=2, req_ready is low in WAIT. Asserting rst in WAIT → no rsp_valid, req_ready=1 next cycle, and an earlier store is still readable.
